// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM sequencing fetch/decode/execute/memory/write-back for the multicycle MIPS datapath
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       instrDone,
  output logic       illegalOp,
  output logic [3:0] state
);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDIEXEC = 4'd11,
    S_ADDIWB   = 4'd12
  } state_t;
  state_t state_q, state_d;
  assign state = state_q;
  // State register; reset is sampled on the clock edge only
  always_ff @(posedge clk) begin
    state_q <= !rst_n ? S_RESET : state_d;
  end
  // Next-state and control decode of the registered state; memReady only stretches FETCH/MEMREAD/MEMWRITE
  always_comb begin
    state_d     = S_RESET;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSource    = 2'b00;
    instrDone   = 1'b0;
    illegalOp   = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
        state_d = memReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        aluSrcB   = 2'b11;
        state_d   = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADDR :
                    (opcode == OP_R)    ? S_EXECUTE  :
                    (opcode == OP_BEQ)  ? S_BRANCH   :
                    (opcode == OP_J)    ? S_JUMP     :
                    (opcode == OP_ADDI) ? S_ADDIEXEC : S_FETCH;
        illegalOp = !(opcode == OP_LW || opcode == OP_SW || opcode == OP_R ||
                      opcode == OP_BEQ || opcode == OP_J || opcode == OP_ADDI);
      end
      S_MEMADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        state_d = memReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        memWrite  = 1'b1;
        iorD      = 1'b1;
        instrDone = memReady;
        state_d   = memReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite  = 1'b1;
        regDst    = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        instrDone   = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pcWrite   = 1'b1;
        pcSource  = 2'b10;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle scoreboard check of the multicycle control FSM
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       memReady = 1'b0;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA, instrDone, illegalOp;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string       tag;
    logic [21:0] exp;
  } sb_t;
  sb_t sb[$];
  // field order: pcWrite pcWriteCond iorD memRead memWrite irWrite memToReg regDst regWrite aluSrcA aluSrcB aluOp pcSource instrDone illegalOp
  localparam logic [17:0] O_RST  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_F0   = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] O_F1   = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] O_DEC  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] O_DECI = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [17:0] O_MA   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] O_MR   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_MWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] O_MW0  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_MW1  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] O_EX   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] O_AWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] O_BR   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] O_J    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] O_AE   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] O_IWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;
  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .instrDone(instrDone), .illegalOp(illegalOp), .state(state)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic rst, input logic mr, input logic [5:0] op,
                     input logic [3:0] st, input logic [17:0] o, input string tag);
    sb_t e;
    logic [21:0] obs;
    @(negedge clk);
    rst_n    = rst;
    memReady = mr;
    opcode   = op;
    sb.push_back('{tag, {st, o}});
    #1;
    e   = sb.pop_front();
    obs = {state, pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
           regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, instrDone, illegalOp};
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
    @(posedge clk);
  endtask
  initial begin
    cyc(0, 0, R, 4'd0, O_RST, "reset_hold");
    cyc(0, 1, R, 4'd0, O_RST, "reset_state");
    cyc(1, 1, R, 4'd0, O_RST, "reset_release");
    cyc(1, 1, R, 4'd1, O_F1,  "r_fetch");
    cyc(1, 1, R, 4'd2, O_DEC, "r_decode");
    cyc(1, 1, R, 4'd7, O_EX,  "r_execute");
    cyc(1, 1, R, 4'd8, O_AWB, "r_aluwb");
    cyc(1, 0, LW, 4'd1, O_F0,  "lw_fetch_wait0");
    cyc(1, 0, LW, 4'd1, O_F0,  "lw_fetch_wait1");
    cyc(1, 1, LW, 4'd1, O_F1,  "lw_fetch");
    cyc(1, 1, LW, 4'd2, O_DEC, "lw_decode");
    cyc(1, 1, LW, 4'd3, O_MA,  "lw_memaddr");
    cyc(1, 0, LW, 4'd4, O_MR,  "lw_memread_wait0");
    cyc(1, 0, LW, 4'd4, O_MR,  "lw_memread_wait1");
    cyc(1, 0, LW, 4'd4, O_MR,  "lw_memread_wait2");
    cyc(1, 1, LW, 4'd4, O_MR,  "lw_memread");
    cyc(1, 1, LW, 4'd5, O_MWB, "lw_memwb");
    cyc(1, 1, SW, 4'd1, O_F1,  "sw_fetch");
    cyc(1, 1, SW, 4'd2, O_DEC, "sw_decode");
    cyc(1, 1, SW, 4'd3, O_MA,  "sw_memaddr");
    cyc(1, 1, SW, 4'd6, O_MW1, "sw_memwrite");
    cyc(1, 1, BEQ, 4'd1, O_F1,  "beq_fetch");
    cyc(1, 1, BEQ, 4'd2, O_DEC, "beq_decode");
    cyc(1, 1, BEQ, 4'd9, O_BR,  "beq_branch");
    cyc(1, 1, J, 4'd1,  O_F1,  "j_fetch");
    cyc(1, 1, J, 4'd2,  O_DEC, "j_decode");
    cyc(1, 1, J, 4'd10, O_J,   "j_jump");
    cyc(1, 1, ADDI, 4'd1,  O_F1,  "addi_fetch");
    cyc(1, 1, ADDI, 4'd2,  O_DEC, "addi_decode");
    cyc(1, 1, ADDI, 4'd11, O_AE,  "addi_exec");
    cyc(1, 1, ADDI, 4'd12, O_IWB, "addi_wb");
    cyc(1, 1, BAD, 4'd1, O_F1,   "bad_fetch");
    cyc(1, 1, BAD, 4'd2, O_DECI, "bad_decode");
    cyc(1, 1, SW, 4'd1, O_F1,  "bad_then_fetch");
    cyc(1, 1, SW, 4'd2, O_DEC, "sw2_decode");
    cyc(1, 1, SW, 4'd3, O_MA,  "sw2_memaddr");
    cyc(1, 0, SW, 4'd6, O_MW0, "sw2_memwrite_wait");
    cyc(0, 0, SW, 4'd6, O_MW0, "sw2_memwrite_rst_edge");
    cyc(1, 0, SW, 4'd0, O_RST, "midreset_state");
    cyc(1, 1, R, 4'd1, O_F1,  "resume_fetch");
    cyc(1, 1, R, 4'd2, O_DEC, "resume_decode");
    cyc(1, 1, R, 4'd7, O_EX,  "resume_execute");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
